whack_mole_datapath: RTL and testbench

WHACK_MOLE_DATAPATH -- requirements
Module: whack_mole_datapath

---
 rtl/whack_mole_if.sv | 29 ++
 rtl/whack_mole_datapath.sv | 144 ++++++++++++++
 tb/tb_whack_mole_datapath.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/whack_mole_if.sv
// Bus between the whack-a-mole game control/buttons and the datapath.
// Groups the game inputs (start, buttons, qualifier) and the datapath outputs.
interface whack_mole_if #(
    parameter int HOLES   = 4,
    parameter int SCORE_W = 8
);
    // Handshake: start is a one-cycle request honoured only while the game is
    // idle or over; a button rising edge counts as a hit only when valid_whack
    // is high in the same cycle, otherwise it is a miss. No back-pressure.
    logic               start;
    logic [HOLES-1:0]   whack;
    logic               valid_whack;
    logic [HOLES-1:0]   mole;
    logic               hit_pulse;
    logic               miss_pulse;
    logic [SCORE_W-1:0] score;
    logic [1:0]         misses;
    logic               game_over;

    modport master (
        output start, whack, valid_whack,
        input  mole, hit_pulse, miss_pulse, score, misses, game_over
    );

    modport slave (
        input  start, whack, valid_whack,
        output mole, hit_pulse, miss_pulse, score, misses, game_over
    );
endinterface

// File: rtl/whack_mole_datapath.sv
// Whack-a-mole datapath: mole placement LFSR, up-window timer, scoring and misses.
// Optional feature: define MOLE_SPEEDUP_EN to shorten the window on every hit.
module whack_mole_datapath #(
    parameter int         HOLES      = 4,
    parameter int         WINDOW     = 50000000,
    parameter int         MAX_MISSES = 3,
    parameter int         SCORE_W    = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        Reset,
    whack_mole_if.slave bus,
    output logic [2:0]  state_dbg
);
    localparam int IW = $clog2(HOLES);
    localparam int TW = $clog2(WINDOW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_UP,
        S_HIT,
        S_MISS,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [HOLES-1:0]   whack_q, whack_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         misses_q, misses_d;
    logic [TW-1:0]      window;
    logic [HOLES-1:0]   whack_edge;
    logic [HOLES-1:0]   mole_bit;
    logic [IW-1:0]      raw_idx;
    logic               start_ok;

    assign whack_edge = bus.whack & ~whack_q;
    assign mole_bit   = HOLES'(1) << idx_q;
    assign raw_idx    = lfsr_q[IW-1:0];
    assign start_ok   = bus.start && (state_q == S_IDLE || state_q == S_OVER);

`ifdef MOLE_SPEEDUP_EN
    localparam logic [TW-1:0] WIN_STEP  = TW'(WINDOW >> 3);
    localparam logic [TW-1:0] WIN_FLOOR = TW'(WINDOW >> 2);

    logic [TW-1:0] window_q, window_d;

    // Each hit shortens the window; a new game restores the full length.
    always_comb begin
        window_d = window_q;
        if (start_ok) begin
            window_d = TW'(WINDOW);
        end else if (state_q == S_HIT) begin
            window_d = (window_q > WIN_FLOOR + WIN_STEP) ? window_q - WIN_STEP : WIN_FLOOR;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            window_q <= TW'(WINDOW);
        end else begin
            window_q <= window_d;
        end
    end

    assign window = window_q;
`else
    assign window = TW'(WINDOW);
`endif

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        whack_d  = bus.whack;
        idx_d    = idx_q;
        timer_d  = timer_q;
        score_d  = score_q;
        misses_d = misses_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_ok) begin
                    score_d  = '0;
                    misses_d = '0;
                    state_d  = S_SPAWN;
                end
            end
            S_SPAWN: begin
                // idx_q still holds the previous mole; never repeat a hole.
                idx_d   = (raw_idx == idx_q) ? IW'(raw_idx + IW'(1)) : raw_idx;
                timer_d = window - TW'(1);
                state_d = S_UP;
            end
            S_UP: begin
                if (whack_edge != '0) begin
                    state_d = (whack_edge == mole_bit && bus.valid_whack) ? S_HIT : S_MISS;
                end else if (timer_q == '0) begin
                    state_d = S_MISS;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_HIT: begin
                score_d = (&score_q) ? score_q : score_q + SCORE_W'(1);
                state_d = S_SPAWN;
            end
            S_MISS: begin
                misses_d = misses_q + 2'd1;
                state_d  = (misses_q + 2'd1 == 2'(MAX_MISSES)) ? S_OVER : S_SPAWN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            whack_q  <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            score_q  <= '0;
            misses_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            whack_q  <= whack_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            score_q  <= score_d;
            misses_q <= misses_d;
        end
    end

    assign bus.mole       = (state_q == S_UP) ? mole_bit : '0;
    assign bus.hit_pulse  = (state_q == S_HIT);
    assign bus.miss_pulse = (state_q == S_MISS);
    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
    assign bus.game_over  = (state_q == S_OVER);
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_whack_mole_datapath.sv
// Testbench for whack_mole_datapath: scripted game table, score saturation run,
// and randomized play checked every cycle against a game-rule model.
module tb_whack_mole_datapath;
    localparam int         HOLES      = 4;
    localparam int         WINDOW     = 16;
    localparam int         MAX_MISSES = 3;
    localparam int         SCORE_W    = 8;
    localparam logic [7:0] SEED       = 8'hA5;
    localparam int         SCORE_MAX  = (1 << SCORE_W) - 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       Reset;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    whack_mole_if #(.HOLES(HOLES), .SCORE_W(SCORE_W)) bus ();

    whack_mole_datapath #(
        .HOLES(HOLES), .WINDOW(WINDOW), .MAX_MISSES(MAX_MISSES),
        .SCORE_W(SCORE_W), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .Reset(Reset), .bus(bus), .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [HOLES-1:0] cur_w = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game-rule model ----------------
    // Phase flags: waiting for start, placing a mole, mole shown, scoring, penalising.
    bit         m_idle = 1, m_spawn = 0, m_up = 0, m_hit = 0, m_miss = 0, m_over = 0;
    bit         m_new = 0;
    logic [7:0] m_lfsr = SEED;
    logic [HOLES-1:0] m_wq = '0;
    int         m_prev = 0, m_old_prev = 0, m_idx = 0, m_left = 0;
    int         m_score = 0, m_misses = 0, m_window = WINDOW;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        // taps 8,6,5,4 -> parity of bits 7,5,4,3
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic model_step(input bit rst, input bit st, input logic [HOLES-1:0] w, input bit v);
        logic [HOLES-1:0] edge_v;
        logic [7:0]       lf;
        int               idx;
        m_new = 0;
        if (rst) begin
            m_lfsr = SEED; m_wq = '0; m_prev = 0; m_idx = 0; m_left = 0;
            m_score = 0; m_misses = 0; m_window = WINDOW;
            m_idle = 1; m_spawn = 0; m_up = 0; m_hit = 0; m_miss = 0; m_over = 0;
        end else begin
            edge_v = w & ~m_wq;
            m_wq   = w;
            lf     = m_lfsr;
            m_lfsr = lfsr_next(lf);
            if (m_idle) begin
                if (st) begin
                    m_score = 0; m_misses = 0; m_over = 0; m_idle = 0; m_spawn = 1;
`ifdef MOLE_SPEEDUP_EN
                    m_window = WINDOW;
`endif
                end
            end else if (m_spawn) begin
                idx = int'(lf) % HOLES;
                if (idx == m_prev) idx = (idx + 1) % HOLES;
                m_old_prev = m_prev;
                m_prev = idx; m_idx = idx; m_left = m_window;
                m_spawn = 0; m_up = 1; m_new = 1;
            end else if (m_up) begin
                if (edge_v != '0) begin
                    m_up = 0;
                    if (edge_v == HOLES'(1 << m_idx) && v) m_hit = 1;
                    else m_miss = 1;
                end else if (m_left == 1) begin
                    m_up = 0; m_miss = 1;
                end else begin
                    m_left--;
                end
            end else if (m_hit) begin
                m_hit = 0; m_spawn = 1;
                if (m_score < SCORE_MAX) m_score++;
`ifdef MOLE_SPEEDUP_EN
                m_window = (m_window - WINDOW / 8 < WINDOW / 4) ? WINDOW / 4 : m_window - WINDOW / 8;
`endif
            end else if (m_miss) begin
                m_miss = 0; m_misses++;
                if (m_misses == MAX_MISSES) begin
                    m_over = 1; m_idle = 1;
                end else begin
                    m_spawn = 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_model();
        check("mole",       32'(bus.mole),       m_up ? 32'(1 << m_idx) : 32'd0);
        check("hit_pulse",  32'(bus.hit_pulse),  32'(m_hit));
        check("miss_pulse", 32'(bus.miss_pulse), 32'(m_miss));
        check("score",      32'(bus.score),      32'(m_score));
        check("misses",     32'(bus.misses),     32'(m_misses));
        check("game_over",  32'(bus.game_over),  32'(m_over));
        if (m_new) check("new_mole_differs", 32'(bus.mole != HOLES'(1 << m_old_prev)), 32'd1);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit rst, input bit st, input logic [HOLES-1:0] w, input bit v);
        Reset = rst; bus.start = st; bus.whack = w; bus.valid_whack = v;
        cur_w = w;
        @(posedge clk);
        model_step(rst, st, w, v);
        @(negedge clk);
        compare_model();
    endtask

    // ---------------- scripted vectors ----------------
    // wsel: 0 release, 1 press current mole, 2 press wrong hole, 3 keep previous buttons
    typedef struct {
        bit rst; bit start; int wsel; bit valid; int reps;
        bit e_up; bit e_hit; bit e_miss; int e_score; int e_misses; bit e_over;
    } vec_t;

    localparam int NV = 24;
    vec_t vec [NV];

    initial begin
        logic [HOLES-1:0] w;
        Reset = 1'b1; bus.start = 1'b0; bus.whack = '0; bus.valid_whack = 1'b0;

        vec[0]  = '{1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0};  // reset
        vec[1]  = '{0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0};  // start -> spawn
        vec[2]  = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0};  // mole up
        vec[3]  = '{0, 0, 1, 1, 1,  0, 1, 0, 0, 0, 0};  // correct hit
        vec[4]  = '{0, 0, 3, 1, 1,  0, 0, 0, 1, 0, 0};  // held, spawn
        vec[5]  = '{0, 0, 3, 1, 1,  1, 0, 0, 1, 0, 0};  // held, no new event
        vec[6]  = '{0, 0, 0, 1, 1,  1, 0, 0, 1, 0, 0};
        vec[7]  = '{0, 0, 2, 1, 1,  0, 0, 1, 1, 0, 0};  // wrong hole
        vec[8]  = '{0, 0, 0, 1, 1,  0, 0, 0, 1, 1, 0};
        vec[9]  = '{0, 0, 0, 1, 1,  1, 0, 0, 1, 1, 0};
        vec[10] = '{0, 0, 1, 0, 1,  0, 0, 1, 1, 1, 0};  // right hole, not qualified
        vec[11] = '{0, 0, 0, 1, 1,  0, 0, 0, 1, 2, 0};
        vec[12] = '{0, 0, 0, 1, 1,  1, 0, 0, 1, 2, 0};
        vec[13] = '{0, 0, 0, 1, 15, 1, 0, 0, 1, 2, 0};
        vec[14] = '{0, 0, 1, 1, 1,  0, 1, 0, 1, 2, 0};  // hit on last window cycle
        vec[15] = '{0, 0, 0, 1, 1,  0, 0, 0, 2, 2, 0};
        vec[16] = '{0, 0, 0, 1, 1,  1, 0, 0, 2, 2, 0};
        vec[17] = '{0, 0, 0, 1, 15, 1, 0, 0, 2, 2, 0};
        vec[18] = '{0, 0, 0, 1, 1,  0, 0, 1, 2, 2, 0};  // timeout after 16 up cycles
        vec[19] = '{0, 0, 0, 1, 1,  0, 0, 0, 2, 3, 1};  // game over
        vec[20] = '{0, 0, 0, 1, 3,  0, 0, 0, 2, 3, 1};
        vec[21] = '{0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0};  // restart clears
        vec[22] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0};
        vec[23] = '{1, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0};  // reset while up

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vec[i].reps; k++) begin
                case (vec[i].wsel)
                    0:       w = '0;
                    1:       w = HOLES'(1 << m_idx);
                    2:       w = HOLES'(1 << ((m_idx + 1) % HOLES));
                    default: w = cur_w;
                endcase
                cycle(vec[i].rst, vec[i].start, w, vec[i].valid);
                check($sformatf("vec%0d_up", i),     32'(bus.mole != '0),   32'(vec[i].e_up));
                check($sformatf("vec%0d_onehot", i), 32'($onehot0(bus.mole)), 32'd1);
                check($sformatf("vec%0d_hit", i),    32'(bus.hit_pulse),    32'(vec[i].e_hit));
                check($sformatf("vec%0d_miss", i),   32'(bus.miss_pulse),   32'(vec[i].e_miss));
                check($sformatf("vec%0d_score", i),  32'(bus.score),        32'(vec[i].e_score));
                check($sformatf("vec%0d_misses", i), 32'(bus.misses),       32'(vec[i].e_misses));
                check($sformatf("vec%0d_over", i),   32'(bus.game_over),    32'(vec[i].e_over));
            end
        end

        // Score saturation: press every mole on its first up cycle (3 cycles per hit).
        cycle(1, 0, '0, 1);
        cycle(0, 1, '0, 1);
        for (int i = 0; i < 900; i++) begin
            cycle(0, 0, m_up ? HOLES'(1 << m_idx) : '0, 1);
        end
        check("score_saturated", 32'(bus.score), 32'(SCORE_MAX));

        // Randomized play against the model.
        cycle(1, 0, '0, 1);
        for (int i = 0; i < 4000; i++) begin
            bit               r, s, v;
            logic [HOLES-1:0] rw;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       rw = '0;
                1:       rw = HOLES'(1 << m_idx);
                2:       rw = HOLES'($urandom_range(0, (1 << HOLES) - 1));
                default: rw = cur_w;
            endcase
            cycle(r, s, rw, v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
